// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer sharing one combinational ALU between two requesters
// over valid/ready request and response channels.
module alu_arbiter #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_src1,
   input  logic [DATA_W-1:0] req0_src2,
   input  logic [3:0]        req0_ctrl,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_src1,
   input  logic [DATA_W-1:0] req1_src2,
   input  logic [3:0]        req1_ctrl,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_result,
   output logic [2:0]        rsp0_zcv,
   output logic              rsp0_err,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_result,
   output logic [2:0]        rsp1_zcv,
   output logic              rsp1_err,
   output logic [DATA_W-1:0] alu_src1,
   output logic [DATA_W-1:0] alu_src2,
   output logic [3:0]        alu_ctrl,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic              alu_cout,
   input  logic              alu_overflow
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state, state_nx;
   logic last_grant, grant, id, err, acc, legal, rsp_done, add_sub;
   logic [DATA_W-1:0] sel_src1, sel_src2;
   logic [3:0] sel_ctrl;
   logic [1:0] rsp_valid_q, err_q;
   logic [1:0][DATA_W-1:0] res_q;
   logic [1:0][2:0] zcv_q;
   always_comb begin
      grant    = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
      sel_src1 = grant ? req1_src1 : req0_src1;
      sel_src2 = grant ? req1_src2 : req0_src2;
      sel_ctrl = grant ? req1_ctrl : req0_ctrl;
      legal    = sel_ctrl inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
      acc      = (state == IDLE) & (grant ? req1_valid : req0_valid);
      rsp_done = rsp_valid_q[id] & (id ? rsp1_ready : rsp0_ready);
      add_sub  = (alu_ctrl == 4'd2) | (alu_ctrl == 4'd6);
      state_nx = state;
      case (state)
         IDLE:    state_nx = acc ? EXEC : IDLE;
         EXEC:    state_nx = RESP;
         RESP:    state_nx = rsp_done ? IDLE : RESP;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   // Illegal codes leave the ALU operands untouched; err masks the captured result instead.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant  <= 1'b1;
         id          <= 1'b0;
         err         <= 1'b0;
         alu_src1    <= '0;
         alu_src2    <= '0;
         alu_ctrl    <= '0;
         rsp_valid_q <= '0;
         err_q       <= '0;
         res_q       <= '0;
         zcv_q       <= '0;
      end else begin
         if (acc) begin
            id         <= grant;
            last_grant <= grant;
            err        <= ~legal;
            if (legal) begin
               alu_src1 <= sel_src1;
               alu_src2 <= sel_src2;
               alu_ctrl <= sel_ctrl;
            end
         end
         if (state == EXEC) begin
            rsp_valid_q[id] <= 1'b1;
            res_q[id]       <= err ? '0 : alu_result;
            zcv_q[id]       <= err ? 3'b000 : {alu_zero, add_sub & alu_cout, add_sub & alu_overflow};
            err_q[id]       <= err;
         end
         if (state == RESP && rsp_done) rsp_valid_q[id] <= 1'b0;
      end
   end
   assign req0_ready  = (state == IDLE) & ~grant;
   assign req1_ready  = (state == IDLE) & grant;
   assign rsp0_valid  = rsp_valid_q[0];
   assign rsp1_valid  = rsp_valid_q[1];
   assign rsp0_result = res_q[0];
   assign rsp1_result = res_q[1];
   assign rsp0_zcv    = zcv_q[0];
   assign rsp1_zcv    = zcv_q[1];
   assign rsp0_err    = err_q[0];
   assign rsp1_err    = err_q[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed traffic against an operation-level reference model,
// with a behavioural ALU attached to the arbiter's ALU port.
module tb_alu_arbiter;
   localparam int DW = 32;
   logic clk = 1'b0, rst_n = 1'b0;
   logic req0_valid, req0_ready, req1_valid, req1_ready;
   logic [DW-1:0] req0_src1, req0_src2, req1_src1, req1_src2;
   logic [3:0] req0_ctrl, req1_ctrl;
   logic rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
   logic [DW-1:0] rsp0_result, rsp1_result;
   logic [2:0] rsp0_zcv, rsp1_zcv;
   logic [DW-1:0] alu_src1, alu_src2, alu_result;
   logic [3:0] alu_ctrl;
   logic alu_zero, alu_cout, alu_overflow;
   int n_tests = 0, n_fail = 0;
   always #5 clk = ~clk;
   alu_arbiter #(.DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_ctrl(req0_ctrl),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_ctrl(req1_ctrl),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zcv(rsp0_zcv), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zcv(rsp1_zcv), .rsp1_err(rsp1_err),
      .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout), .alu_overflow(alu_overflow)
   );
   // Behavioural ALU; carry/overflow read 1 on non-arithmetic ops so the masking is observable.
   logic [DW:0] sum;
   logic [DW-1:0] b_eff;
   always_comb begin
      b_eff = (alu_ctrl == 4'd6) ? ~alu_src2 : alu_src2;
      sum = {1'b0, alu_src1} + {1'b0, b_eff} + {32'b0, alu_ctrl == 4'd6};
      case (alu_ctrl)
         4'd0:    alu_result = alu_src1 & alu_src2;
         4'd1:    alu_result = alu_src1 | alu_src2;
         4'd2, 4'd6: alu_result = sum[DW-1:0];
         4'd7:    alu_result = {31'b0, $signed(alu_src1) < $signed(alu_src2)};
         4'd12:   alu_result = ~(alu_src1 | alu_src2);
         default: alu_result = '0;
      endcase
      alu_zero = alu_result == '0;
      alu_cout = (alu_ctrl == 4'd2 || alu_ctrl == 4'd6) ? sum[DW] : 1'b1;
      alu_overflow = (alu_ctrl == 4'd2 || alu_ctrl == 4'd6) ?
                     (alu_src1[DW-1] == b_eff[DW-1]) && (sum[DW-1] != alu_src1[DW-1]) : 1'b1;
   end
   // Operation-level reference: {err, zcv, result}.
   function automatic logic [35:0] ref_op(logic [31:0] a, logic [31:0] b, logic [3:0] c);
      logic [31:0] r;
      logic co, v, e;
      r = '0; co = 1'b0; v = 1'b0; e = 1'b0;
      case (c)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd2:  begin {co, r} = {1'b0, a} + {1'b0, b}; v = (a[31] == b[31]) && (r[31] != a[31]); end
         4'd6:  begin r = a - b; co = a >= b; v = (a[31] != b[31]) && (r[31] != a[31]); end
         4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd12: r = ~(a | b);
         default: e = 1'b1;
      endcase
      return e ? {1'b1, 35'b0} : {1'b0, r == 32'd0, co, v, r};
   endfunction
   bit hv [2];
   bit rr [2];
   logic [31:0] hs1 [2], hs2 [2];
   logic [3:0] hc [2];
   bit busy, last;
   int age, owner;
   bit ev [2], ee [2];
   logic [31:0] er [2];
   logic [2:0] ez [2];
   logic [35:0] pend;
   logic [31:0] ea1, ea2;
   logic [3:0] ec;
   task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask
   task automatic model_reset();
      busy = 0; last = 1; age = 0; owner = 0; pend = '0;
      ea1 = '0; ea2 = '0; ec = '0;
      for (int p = 0; p < 2; p++) begin
         ev[p] = 0; ee[p] = 0; er[p] = '0; ez[p] = '0; hv[p] = 0;
      end
   endtask
   task automatic check_outs();
      check("rsp0_valid", rsp0_valid, ev[0]);
      check("rsp1_valid", rsp1_valid, ev[1]);
      check("rsp0_result", rsp0_result, er[0]);
      check("rsp1_result", rsp1_result, er[1]);
      check("rsp0_zcv", rsp0_zcv, ez[0]);
      check("rsp1_zcv", rsp1_zcv, ez[1]);
      check("rsp0_err", rsp0_err, ee[0]);
      check("rsp1_err", rsp1_err, ee[1]);
      check("alu_src1", alu_src1, ea1);
      check("alu_src2", alu_src2, ea2);
      check("alu_ctrl", alu_ctrl, ec);
   endtask
   task automatic step();
      int w;
      check_outs();
      req0_valid = hv[0]; req0_src1 = hs1[0]; req0_src2 = hs2[0]; req0_ctrl = hc[0];
      req1_valid = hv[1]; req1_src1 = hs1[1]; req1_src2 = hs2[1]; req1_ctrl = hc[1];
      rsp0_ready = rr[0]; rsp1_ready = rr[1];
      #1;
      w = (hv[0] && hv[1]) ? int'(!last) : int'(hv[1]);
      check("req0_ready", req0_ready, !busy && w == 0);
      check("req1_ready", req1_ready, !busy && w == 1);
      if (!busy) begin
         if (hv[w]) begin
            busy = 1; age = 0; owner = w; last = w[0];
            pend = ref_op(hs1[w], hs2[w], hc[w]);
            if (!pend[35]) begin ea1 = hs1[w]; ea2 = hs2[w]; ec = hc[w]; end
            hv[w] = 0;
         end
      end else if (age == 0) begin
         age = 1; ev[owner] = 1;
         er[owner] = pend[31:0]; ez[owner] = pend[34:32]; ee[owner] = pend[35];
      end else if (rr[owner]) begin
         ev[owner] = 0; busy = 0;
      end
      @(negedge clk);
   endtask
   task automatic issue(int p, logic [31:0] a, logic [31:0] b, logic [3:0] c);
      hv[p] = 1; hs1[p] = a; hs2[p] = b; hc[p] = c;
   endtask
   task automatic rand_issue(int p);
      logic [3:0] codes [6];
      logic [31:0] edges [5];
      logic [31:0] a, b;
      codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
      edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      issue(p, a, b, ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 5)]);
   endtask
   task automatic drain();
      int n = 0;
      rr[0] = 1; rr[1] = 1;
      while ((busy || hv[0] || hv[1]) && n < 50) begin step(); n++; end
      check("drain_timeout", n < 50, 1);
      step();
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      model_reset();
      rr[0] = 0; rr[1] = 0;
      req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
      req0_src1 = '0; req0_src2 = '0; req0_ctrl = '0;
      req1_src1 = '0; req1_src2 = '0; req1_ctrl = '0;
      repeat (2) @(negedge clk);
      check_outs();
      rst_n = 1;
      step();
      issue(0, 32'h1, 32'hFFFF_FFFF, 4'd2);
      drain();
      issue(1, 32'h8000_0000, 32'h1, 4'd6);
      drain();
      issue(1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'd0);
      drain();
      rr[0] = 1; rr[1] = 1;
      for (int i = 0; i < 20; i++) begin
         if (!hv[0]) issue(0, 32'h1, 32'h2, 4'd1);
         if (!hv[1]) issue(1, 32'd5, 32'd7, 4'd7);
         step();
      end
      drain();
      issue(0, 32'd3, 32'd4, 4'd2);
      rr[0] = 0;
      step();
      issue(1, 32'd9, 32'd9, 4'd6);
      repeat (7) step();
      rr[0] = 1;
      drain();
      issue(0, 32'd10, 32'd20, 4'd2);
      drain();
      issue(0, 32'h1, 32'h2, 4'd3);
      drain();
      rr[0] = 0;
      issue(0, 32'd7, 32'd8, 4'd2);
      repeat (3) step();
      check("pre_reset_rsp0_valid", rsp0_valid, 1);
      req0_valid = 1; req1_valid = 1;
      rst_n = 0;
      #1;
      model_reset();
      check_outs();
      check("reset_req0_ready", req0_ready, 1);
      check("reset_req1_ready", req1_ready, 0);
      @(negedge clk);
      rst_n = 1;
      issue(0, 32'h1, 32'h2, 4'd1);
      issue(1, 32'd5, 32'd7, 4'd7);
      drain();
      for (int i = 0; i < 3000; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!hv[p] && $urandom_range(0, 2) == 0) rand_issue(p);
            rr[p] = $urandom_range(0, 3) != 0;
         end
         step();
      end
      drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
